router_wrap_buf: RTL

Parametrised, buffered successor to the pass-through router wrapper used as the whitebox simulation model of the NoC router tile. Each of `NUM_PORTS` input channels feeds a per-port FIFO that drains to the same-index output channel under credit-based flow control. A credit is returned upstream for every flit forwarded. Overflow and credit-protocol violations are flagged on a sticky error output.

---
 rtl/router_wrap_pkg.sv | 26 ++
 rtl/router_port_buf.sv | 99 +++++++++
 rtl/router_wrap_buf.sv | 50 +++++
 3 files changed

// File: rtl/router_wrap_pkg.sv
// Channel and flow-control field layout shared by the buffered router wrapper.
// Helpers take a zero-extended word so a single definition serves every channel width.
package router_wrap_pkg;

    localparam int CH_VALID_BIT = 0;
    localparam int CH_VC_LSB    = 1;
    localparam int FC_VALID_BIT = 0;
    localparam int FC_VC_LSB    = 1;
    localparam int MAX_CHAN_W   = 256;
    localparam int MAX_VC_W     = 8;

    function automatic logic get_flit_valid(input logic [MAX_CHAN_W-1:0] word);
        return word[CH_VALID_BIT];
    endfunction

    function automatic logic [MAX_VC_W-1:0] get_flit_vc(input logic [MAX_CHAN_W-1:0] word,
                                                        input int vc_w);
        logic [MAX_VC_W-1:0] vc;
        vc = '0;
        for (int i = 0; i < MAX_VC_W; i++) begin
            if (i < vc_w) vc[i] = word[CH_VC_LSB + i];
        end
        return vc;
    endfunction

endpackage

// File: rtl/router_port_buf.sv
// One router port: input FIFO drained under a downstream credit count, with a
// sticky error for dropped flits and credits returned beyond the pool size.
module router_port_buf
    import router_wrap_pkg::*;
#(
    parameter int CHAN_W    = 38,
    parameter int VC_W      = 2,
    parameter int FC_W      = 3,
    parameter int BUF_DEPTH = 4,
    parameter int CREDITS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAN_W-1:0] chan_in,
    input  logic [FC_W-1:0]   fc_in,
    output logic [CHAN_W-1:0] chan_out,
    output logic [FC_W-1:0]   fc_out,
    output logic              err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int CR_W  = $clog2(CREDITS + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [CR_W-1:0]  MAX_CR   = CR_W'(CREDITS);

    logic [CHAN_W-1:0]   mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CR_W-1:0]     credits;
    logic [MAX_VC_W-1:0] head_vc;
    logic                in_valid;
    logic                cr_valid;
    logic                can_deq;
    logic                full;
    logic                do_enq;
    logic                drop;
    logic                cr_ovf;
    logic                unused_bits;

    assign in_valid = get_flit_valid(MAX_CHAN_W'(chan_in));
    assign head_vc  = get_flit_vc(MAX_CHAN_W'(mem[rd_ptr]), VC_W);
    assign cr_valid = fc_in[FC_VALID_BIT];

    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign can_deq = (count != '0) && (credits != '0);
    assign full    = (count == FULL_CNT);
    assign do_enq  = in_valid && (!full || can_deq);
    assign drop    = in_valid && full && !can_deq;
    assign cr_ovf  = cr_valid && !can_deq && (credits == MAX_CR);

    // The credit VC id is ignored: one pool covers every VC on the port.
    assign unused_bits = ^{fc_in, head_vc};

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= chan_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            credits  <= MAX_CR;
            chan_out <= '0;
            fc_out   <= '0;
            err      <= 1'b0;
        end else begin
            if (do_enq) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);

            if (can_deq) begin
                rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                chan_out <= mem[rd_ptr];
                fc_out   <= {head_vc[VC_W-1:0], 1'b1};
            end else begin
                chan_out <= '0;
                fc_out   <= '0;
            end

            if (do_enq && !can_deq) begin
                count <= count + CNT_W'(1);
            end else if (can_deq && !do_enq) begin
                count <= count - CNT_W'(1);
            end

            if (can_deq && !cr_valid) begin
                credits <= credits - CR_W'(1);
            end else if (cr_valid && !can_deq && credits != MAX_CR) begin
                credits <= credits + CR_W'(1);
            end

            if (drop || cr_ovf) err <= 1'b1;
        end
    end

endmodule

// File: rtl/router_wrap_buf.sv
// Buffered router wrapper: NUM_PORTS independent credit-controlled FIFOs,
// each port's input feeding only its own output.
module router_wrap_buf
    import router_wrap_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int CHAN_W    = 38,
    parameter int VC_W      = 2,
    parameter int FC_W      = 1 + VC_W,
    parameter int BUF_DEPTH = 4,
    parameter int CREDITS   = 4,
    parameter int ADDR_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           router_address,
    input  logic [NUM_PORTS*CHAN_W-1:0] channel_in_ip,
    output logic [NUM_PORTS*FC_W-1:0]   flow_ctrl_out_ip,
    output logic [NUM_PORTS*CHAN_W-1:0] channel_out_op,
    input  logic [NUM_PORTS*FC_W-1:0]   flow_ctrl_in_op,
    output logic                        error,
    output logic [NUM_PORTS-1:0]        err_port
);

    logic unused_addr;

    // Kept only so the pin list matches the pass-through wrapper it replaces.
    assign unused_addr = ^router_address;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        router_port_buf #(
            .CHAN_W   (CHAN_W),
            .VC_W     (VC_W),
            .FC_W     (FC_W),
            .BUF_DEPTH(BUF_DEPTH),
            .CREDITS  (CREDITS)
        ) u_buf (
            .clk     (clk),
            .reset   (reset),
            .chan_in (channel_in_ip[p*CHAN_W +: CHAN_W]),
            .fc_in   (flow_ctrl_in_op[p*FC_W +: FC_W]),
            .chan_out(channel_out_op[p*CHAN_W +: CHAN_W]),
            .fc_out  (flow_ctrl_out_ip[p*FC_W +: FC_W]),
            .err     (err_port[p])
        );
    end

    assign error = |err_port;

endmodule
